// File: rtl/priority_pkg.sv
// Shared definitions for the priority/round-robin arbiter.
//   MODE_FIXED / MODE_RR : arbitration mode selectors
//   state_t              : grant FSM encoding
//   clog2                : elaboration-time ceil(log2) used for code/index widths
package priority_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Smallest r with (1 << r) >= v; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/priority_arbiter_rr_if.sv
// Request/grant bundle between request sources, the arbiter and the grant consumer.
//   n_en         : active-low enable
//   req_n[N]     : active-low request lines
//   grant_ready  : consumer accepts the current grant
//   grant_valid  : grant_code/grant_onehot hold a valid grant
//   grant_code   : winning index + 1, 0 = none
//   grant_onehot : one-hot of the winning index, 0 = none
//   et           : registered enable status
// slave modport = arbiter side, master modport = driver/consumer side.
interface priority_arbiter_rr_if #(
    parameter int N = 7
);
    localparam int CW = priority_pkg::clog2(N + 1);

    logic          n_en;
    logic [N-1:0]  req_n;
    logic          grant_ready;
    logic          grant_valid;
    logic [CW-1:0] grant_code;
    logic [N-1:0]  grant_onehot;
    logic          et;

    modport slave (
        input  n_en, req_n, grant_ready,
        output grant_valid, grant_code, grant_onehot, et
    );

    modport master (
        output n_en, req_n, grant_ready,
        input  grant_valid, grant_code, grant_onehot, et
    );

endinterface

// File: rtl/priority_arbiter_rr_search.sv
// prio_search: combinational winner search over a candidate vector.
//   cand[N] : candidate bits
//   ptr     : round-robin pointer (ignored in fixed mode)
//   found   : any candidate set
//   idx     : winning index
//   onehot  : one-hot of idx, 0 when nothing found
// The vector is rotated so that bit ptr-1 lands on the top position, the
// highest set bit is taken, and the result is rotated back. With ptr=0 this
// degenerates to plain highest-index priority.
module prio_search
    import priority_pkg::*;
#(
    parameter int N    = 7,
    parameter int MODE = MODE_FIXED,
    parameter int IW   = clog2(N)
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    logic [IW-1:0] base;
    logic [N-1:0]  rot;
    logic [IW-1:0] jw;
    logic [IW:0]   ks;

    assign base = (MODE == MODE_RR) ? ptr : '0;

    always_comb begin
        rot    = '0;
        jw     = '0;
        found  = 1'b0;
        ks     = '0;
        // rot[j] = cand[(base + j) mod N]; rot[N-1] is cand[base-1]
        for (int j = 0; j < N; j++) begin
            ks = {1'b0, base} + (IW+1)'(j);
            if (ks >= (IW+1)'(N)) ks = ks - (IW+1)'(N);
            rot[j] = cand[ks[IW-1:0]];
        end
        // last hit wins, so this yields the highest set rotated position
        for (int j = 0; j < N; j++) begin
            if (rot[j]) begin
                jw    = IW'(j);
                found = 1'b1;
            end
        end
        ks = {1'b0, base} + {1'b0, jw};
        if (ks >= (IW+1)'(N)) ks = ks - (IW+1)'(N);
        idx    = ks[IW-1:0];
        onehot = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr: registered arbiter over N active-low request lines.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request/grant bundle (slave side)
// Requests are latched into sticky pending bits; one grant at a time is
// offered on a valid/ready handshake and, when accepted, the next winner is
// loaded in the same edge so a busy request set yields one grant per cycle.
module priority_arbiter_rr
    import priority_pkg::*;
#(
    parameter int N    = 7,
    parameter int MODE = MODE_FIXED
) (
    input  logic                  clk,
    input  logic                  rst,
    priority_arbiter_rr_if.slave  bus
);

    localparam int CW = clog2(N + 1);
    localparam int IW = clog2(N);

    state_t        state;
    logic [N-1:0]  pending;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win_idx;

    logic [N-1:0]  new_req;
    logic [N-1:0]  clr;
    logic [N-1:0]  pend_nx;
    logic          accept;
    logic [IW-1:0] s_ptr;
    logic          s_found;
    logic [IW-1:0] s_idx;
    logic [N-1:0]  s_onehot;

    assign new_req = bus.n_en ? '0 : ~bus.req_n;
    assign accept  = (state == GRANT) && bus.grant_ready;
    assign clr     = accept ? bus.grant_onehot : '0;
    // set wins over clear: an accepted line still requesting stays pending
    assign pend_nx = (pending & ~clr) | new_req;

    // In IDLE pend_nx equals pending|new, and after an accept it is exactly
    // the remaining candidate set, so one search serves both cases. The
    // search already sees the pointer that this accept will commit.
    assign s_ptr = (MODE == MODE_RR && accept) ? win_idx : ptr;

    prio_search #(
        .N    (N),
        .MODE (MODE),
        .IW   (IW)
    ) u_search (
        .cand   (pend_nx),
        .ptr    (s_ptr),
        .found  (s_found),
        .idx    (s_idx),
        .onehot (s_onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            pending          <= '0;
            ptr              <= '0;
            win_idx          <= '0;
            bus.grant_valid  <= 1'b0;
            bus.grant_code   <= '0;
            bus.grant_onehot <= '0;
            bus.et           <= 1'b0;
        end else begin
            bus.et <= ~bus.n_en;
            if (bus.n_en) begin
                // disable aborts any grant; ptr is deliberately kept
                state            <= IDLE;
                pending          <= '0;
                bus.grant_valid  <= 1'b0;
                bus.grant_code   <= '0;
                bus.grant_onehot <= '0;
            end else begin
                pending <= pend_nx;
                if (accept && MODE == MODE_RR) ptr <= win_idx;
                if (state == IDLE || accept) begin
                    if (s_found) begin
                        state            <= GRANT;
                        win_idx          <= s_idx;
                        bus.grant_valid  <= 1'b1;
                        bus.grant_code   <= CW'(s_idx) + CW'(1);
                        bus.grant_onehot <= s_onehot;
                    end else begin
                        state            <= IDLE;
                        bus.grant_valid  <= 1'b0;
                        bus.grant_code   <= '0;
                        bus.grant_onehot <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed bench: u0 is fixed priority, u1 is round-robin, both N=7 and fed
// identical stimulus. Inputs change and outputs are sampled on the falling edge.
module tb_priority_arbiter_rr;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    priority_arbiter_rr_if #(.N(7)) if0 ();
    priority_arbiter_rr_if #(.N(7)) if1 ();

    priority_arbiter_rr #(.N(7), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    priority_arbiter_rr #(.N(7), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

    logic [10:0] obs0, obs1;
    assign obs0 = {if0.grant_valid, if0.grant_code, if0.grant_onehot};
    assign obs1 = {if1.grant_valid, if1.grant_code, if1.grant_onehot};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {valid, code, onehot} expected for a given code (0 = no grant)
    function automatic logic [10:0] exp_of(input int c);
        if (c == 0) return '0;
        return {1'b1, 3'(c), 7'(1 << (c - 1))};
    endfunction

    task automatic drv(input logic en_n, input logic [6:0] r, input logic rdy);
        if0.n_en = en_n; if0.req_n = r; if0.grant_ready = rdy;
        if1.n_en = en_n; if1.req_n = r; if1.grant_ready = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv(1'b1, 7'h7f, 1'b0);
        #1;
        total++;
        if (obs0 !== '0 || if0.et !== 1'b0) begin
            bad++; $display("FAIL reset_u0: got %b et=%b want 0", obs0, if0.et);
        end
        total++;
        if (obs1 !== '0 || if1.et !== 1'b0) begin
            bad++; $display("FAIL reset_u1: got %b et=%b want 0", obs1, if1.et);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drv(1'b0, 7'h7f, 1'b0);
        @(negedge clk);
        total++;
        if (obs0 !== '0) begin
            bad++; $display("FAIL reset_idle: got %b want 0", obs0);
        end
    endtask

    // all lines held low with ready high: u1 rotates, u0 keeps granting 7
    task automatic test_rr();
        drv(1'b0, 7'h00, 1'b1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            total++;
            if (obs1 !== exp_of(7 - (i % 7))) begin
                bad++; $display("FAIL rr_seq[%0d]: got %b want %b", i, obs1, exp_of(7 - (i % 7)));
            end
            total++;
            if (obs0 !== exp_of(7)) begin
                bad++; $display("FAIL fixed_hog[%0d]: got %b want %b", i, obs0, exp_of(7));
            end
        end
        drv(1'b1, 7'h7f, 1'b0);
        @(negedge clk);
        total++;
        if (obs0 !== '0 || obs1 !== '0) begin
            bad++; $display("FAIL rr_disable: got %b/%b want 0", obs0, obs1);
        end
        drv(1'b0, 7'h7f, 1'b0);
    endtask

    // bits 0 and 6 for one cycle: 7 then 1 then idle
    task automatic test_fixed();
        int codes[3] = '{7, 1, 0};
        drv(1'b0, 7'b0111110, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) drv(1'b0, 7'h7f, 1'b1);
            total++;
            if (obs0 !== exp_of(codes[i])) begin
                bad++; $display("FAIL fixed_b2b[%0d]: got %b want %b", i, obs0, exp_of(codes[i]));
            end
        end
        drv(1'b0, 7'h7f, 1'b0);
    endtask

    // one-cycle pulse on line 3 while grant 7 is stalled
    task automatic test_pulse();
        int codes[5] = '{7, 7, 7, 4, 0};
        drv(1'b0, 7'b0111111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (obs0 !== exp_of(codes[i])) begin
                bad++; $display("FAIL pulse[%0d]: got %b want %b", i, obs0, exp_of(codes[i]));
            end
            case (i)
                0: drv(1'b0, 7'b1110111, 1'b0);
                1: drv(1'b0, 7'h7f, 1'b0);
                2: drv(1'b0, 7'h7f, 1'b1);
                default: ;
            endcase
        end
        drv(1'b0, 7'h7f, 1'b0);
    endtask

    task automatic test_disable();
        drv(1'b0, 7'b1101111, 1'b0);
        @(negedge clk);
        total++;
        if (obs0 !== exp_of(5) || if0.et !== 1'b1) begin
            bad++; $display("FAIL dis_hold: got %b et=%b want %b et=1", obs0, if0.et, exp_of(5));
        end
        drv(1'b1, 7'h7f, 1'b1);  // ready in the disable cycle is ignored
        @(negedge clk);
        total++;
        if (obs0 !== '0 || if0.et !== 1'b0) begin
            bad++; $display("FAIL dis_abort: got %b et=%b want 0 et=0", obs0, if0.et);
        end
        drv(1'b0, 7'h7f, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (obs0 !== '0 || if0.et !== 1'b1) begin
                bad++; $display("FAIL dis_noresume[%0d]: got %b et=%b want 0 et=1", i, obs0, if0.et);
            end
        end
        drv(1'b0, 7'b1111101, 1'b1);
        @(negedge clk);
        drv(1'b0, 7'h7f, 1'b1);
        total++;
        if (obs0 !== exp_of(2)) begin
            bad++; $display("FAIL dis_resume: got %b want %b", obs0, exp_of(2));
        end
        @(negedge clk);
        total++;
        if (obs0 !== '0) begin
            bad++; $display("FAIL dis_drain: got %b want 0", obs0);
        end
        drv(1'b0, 7'h7f, 1'b0);
    endtask

    task automatic test_async_reset();
        drv(1'b0, 7'b1011011, 1'b0);
        @(negedge clk);
        drv(1'b0, 7'h7f, 1'b0);
        total++;
        if (obs0 !== exp_of(6)) begin
            bad++; $display("FAIL ar_pre: got %b want %b", obs0, exp_of(6));
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (obs0 !== '0 || obs1 !== '0 || if0.et !== 1'b0) begin
            bad++; $display("FAIL ar_clear: got %b/%b et=%b want 0", obs0, obs1, if0.et);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (obs0 !== '0) begin
            bad++; $display("FAIL ar_nopend: got %b want 0", obs0);
        end
        drv(1'b0, 7'b1011011, 1'b1);
        @(negedge clk);
        drv(1'b0, 7'h7f, 1'b1);
        total++;
        if (obs0 !== exp_of(6) || obs1 !== exp_of(6)) begin
            bad++; $display("FAIL ar_first: got %b/%b want %b", obs0, obs1, exp_of(6));
        end
        @(negedge clk);
        total++;
        if (obs0 !== exp_of(3) || obs1 !== exp_of(3)) begin
            bad++; $display("FAIL ar_second: got %b/%b want %b", obs0, obs1, exp_of(3));
        end
        @(negedge clk);
        total++;
        if (obs0 !== '0) begin
            bad++; $display("FAIL ar_idle: got %b want 0", obs0);
        end
        drv(1'b0, 7'h7f, 1'b0);
    endtask

    // line 2 held through its own accept stays pending and wins again
    task automatic test_regrant();
        int codes[4] = '{3, 3, 1, 0};
        drv(1'b0, 7'b1111011, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (obs0 !== exp_of(codes[i])) begin
                bad++; $display("FAIL regrant[%0d]: got %b want %b", i, obs0, exp_of(codes[i]));
            end
            case (i)
                0: drv(1'b0, 7'b1111010, 1'b1);
                1: drv(1'b0, 7'h7f, 1'b1);
                default: ;
            endcase
        end
        drv(1'b0, 7'h7f, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_rr();
        test_fixed();
        test_pulse();
        test_disable();
        test_async_reset();
        test_regrant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
